// File: rtl/apb2wb_pkg.sv
// rtl/apb2wb_pkg.sv - shared types and constants for the APB3 to Wishbone B4 bridge
// Contents: bridge FSM state enum, fixed Wishbone cycle-type constants,
// and the widths of the retry and timeout counters.
package apb2wb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WB_REQ    = 2'd1,
        RETRY_GAP = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam int RETRY_W = 4;
    localparam int TO_W    = 8;

endpackage

// File: rtl/apb2wb_watchdog.sv
// rtl/apb2wb_watchdog.sv - retry and timeout counters for the APB to Wishbone bridge
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   clear            start of a new transfer: zero both counters
//   rty              accepted rty_i that will be re-issued: bump the retry count
//   busy             stb_o is high this cycle; timeout counts only while busy
//   retry_exhausted  retry count has reached MAX_RETRY
//   timed_out        this busy cycle is the TIMEOUT-th without a response
module apb2wb_watchdog
    import apb2wb_pkg::*;
#(
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic rty,
    input  logic busy,
    output logic retry_exhausted,
    output logic timed_out
);

    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT - 1);

    logic [RETRY_W-1:0] retry_cnt;
    logic [TO_W-1:0]    to_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            retry_cnt <= '0;
            to_cnt    <= '0;
        end else if (clear) begin
            retry_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            if (rty && (retry_cnt != RETRY_MAX)) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            // Any cycle with stb_o low (retry gap, done) restarts the window,
            // so each re-issue gets a full TIMEOUT budget of its own.
            if (busy) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end

    assign retry_exhausted = (retry_cnt == RETRY_MAX);
    // to_cnt holds the number of busy cycles already elapsed, so the
    // TIMEOUT-th busy cycle is the one where it equals TIMEOUT-1.
    assign timed_out       = busy && (to_cnt == TO_LAST);

endmodule

// File: rtl/apb2wb_bridge.sv
// rtl/apb2wb_bridge.sv - APB3 completer to Wishbone B4 classic single-beat initiator
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   paddr/psel/penable/pwrite/pwdata/pstrb  APB request side
//   pready/prdata/pslverr               APB response, all registered
//   adr_o/dat_o/cyc_o/stb_o/we_o/sel_o  Wishbone request
//   cti_o/bte_o                         fixed classic cycle, linear burst
//   dat_i/ack_i/err_i/rty_i             Wishbone slave response
module apb2wb_bridge
    import apb2wb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   paddr,
    input  logic            psel,
    input  logic            penable,
    input  logic            pwrite,
    input  logic [DW-1:0]   pwdata,
    input  logic [DW/8-1:0] pstrb,
    output logic            pready,
    output logic [DW-1:0]   prdata,
    output logic            pslverr,
    output logic [AW-1:0]   adr_o,
    output logic [DW-1:0]   dat_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [DW/8-1:0] sel_o,
    output logic [2:0]      cti_o,
    output logic [1:0]      bte_o,
    input  logic [DW-1:0]   dat_i,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic            rty_i
);

    state_t state, next_state;

    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] strb_q;
    logic            we_q;
    logic            pready_q;
    logic            pslverr_q;
    logic [DW-1:0]   prdata_q;

    logic latch;
    logic done_err;
    logic wd_clear;
    logic wd_rty;
    logic wd_busy;
    logic retry_exhausted;
    logic timed_out;

    apb2wb_watchdog #(
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .clk             (clk),
        .reset           (reset),
        .clear           (wd_clear),
        .rty             (wd_rty),
        .busy            (wd_busy),
        .retry_exhausted (retry_exhausted),
        .timed_out       (timed_out)
    );

    always_comb begin
        next_state = state;
        latch      = 1'b0;
        done_err   = 1'b0;
        wd_clear   = 1'b0;
        wd_rty     = 1'b0;
        wd_busy    = (state == WB_REQ);
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    latch      = 1'b1;
                    wd_clear   = 1'b1;
                    next_state = WB_REQ;
                end
            end
            WB_REQ: begin
                if (err_i) begin
                    done_err   = 1'b1;
                    next_state = DONE;
                end else if (ack_i) begin
                    next_state = DONE;
                end else if (rty_i) begin
                    if (retry_exhausted) begin
                        done_err   = 1'b1;
                        next_state = DONE;
                    end else begin
                        wd_rty     = 1'b1;
                        next_state = RETRY_GAP;
                    end
                end else if (timed_out) begin
                    done_err   = 1'b1;
                    next_state = DONE;
                end
            end
            RETRY_GAP: next_state = WB_REQ;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            we_q      <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state     <= next_state;
            pready_q  <= (next_state == DONE);
            pslverr_q <= done_err;
            if (latch) begin
                addr_q  <= paddr;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
                we_q    <= pwrite;
            end
            // Reads that end in error return zero; writes leave prdata alone.
            if ((state == WB_REQ) && (next_state == DONE) && !we_q) begin
                prdata_q <= done_err ? '0 : dat_i;
            end
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

    assign cyc_o = (state == WB_REQ);
    assign stb_o = (state == WB_REQ);
    assign adr_o = addr_q;
    assign dat_o = wdata_q;
    assign we_o  = we_q;
    // Gated so that sel_o reads as zero whenever no cycle is in flight.
    assign sel_o = (state != WB_REQ) ? '0 : (we_q ? strb_q : '1);
    assign cti_o = CTI_CLASSIC;
    assign bte_o = BTE_LINEAR;

endmodule

// File: tb/tb_apb2wb_bridge.sv
// tb/tb_apb2wb_bridge.sv - self-checking bench for apb2wb_bridge
module tb_apb2wb_bridge;

    localparam int TIMEOUT   = 255;
    localparam int MAX_RETRY = 3;

    localparam int R_ACK    = 0;
    localparam int R_ERR    = 1;
    localparam int R_RTY    = 2;
    localparam int R_ERRACK = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;

    apb2wb_bridge #(
        .AW(32), .DW(32), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .adr_o(adr_o), .dat_o(dat_o), .cyc_o(cyc_o), .stb_o(stb_o),
        .we_o(we_o), .sel_o(sel_o), .cti_o(cti_o), .bte_o(bte_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Slave script: attempt k waits att_wait[k] stb cycles, then answers att_resp[k].
    int att_wait [8];
    int att_resp [8];
    int n_att;

    logic [31:0] exp_prdata = 32'h0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: how many stb cycles, how many gap cycles and whether the
    // transfer errors, derived from the slave script alone.
    function automatic void model(output int stb, output int gap, output logic err);
        int retries;
        stb = 0; gap = 0; err = 1'b0; retries = 0;
        for (int k = 0; k < n_att; k++) begin
            if (att_wait[k] >= TIMEOUT) begin
                stb += TIMEOUT; err = 1'b1; return;
            end
            stb += att_wait[k] + 1;
            if (att_resp[k] == R_ERR || att_resp[k] == R_ERRACK) begin
                err = 1'b1; return;
            end
            if (att_resp[k] == R_ACK) return;
            if (retries == MAX_RETRY) begin
                err = 1'b1; return;
            end
            retries++;
            gap++;
        end
    endfunction

    task automatic run_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] st, input logic [31:0] rd);
        int exp_stb, exp_gap, cyc, stb_seen, gap_seen, at, w;
        logic exp_err, done;
        model(exp_stb, exp_gap, exp_err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st; dat_i = rd;
        cyc = 0; stb_seen = 0; gap_seen = 0; at = 0; w = 0; done = 1'b0;
        while (!done && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            penable = 1'b1; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
            if (pready) begin
                done = 1'b1;
                check("pready_cycle", 128'(cyc), 128'(exp_stb + exp_gap + 1));
                check("pslverr", 128'(pslverr), 128'(exp_err));
                check("stb_cycles", 128'(stb_seen), 128'(exp_stb));
                check("gap_cycles", 128'(gap_seen), 128'(exp_gap));
                check("cyc_stb_in_done", 128'({cyc_o, stb_o}), 128'(0));
                if (!wr) exp_prdata = exp_err ? 32'h0 : rd;
                check("prdata", 128'(prdata), 128'(exp_prdata));
            end else if (stb_o) begin
                stb_seen++;
                check("wb_req", 128'({cyc_o, adr_o, dat_o, we_o, sel_o, cti_o, bte_o}),
                      128'({1'b1, a, wd, wr, (wr ? st : 4'hf), 3'b000, 2'b00}));
                if (at < n_att && w == att_wait[at]) begin
                    case (att_resp[at])
                        R_ACK:    ack_i = 1'b1;
                        R_ERR:    err_i = 1'b1;
                        R_RTY:    rty_i = 1'b1;
                        default: begin ack_i = 1'b1; err_i = 1'b1; end
                    endcase
                    at++;
                    w = 0;
                end else begin
                    w++;
                end
            end else begin
                gap_seen++;
            end
        end
        check("pready_seen", 128'(done), 128'(1));
        psel = 1'b0; penable = 1'b0;
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
    endtask

    initial begin
        logic wr;
        int   r;
        reset = 1'b1;
        paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
        dat_i = '0; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_apb", 128'({pready, pslverr, prdata}), 128'(0));
        check("reset_wb", 128'({cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, cti_o, bte_o}), 128'(0));
        reset = 1'b0;

        // Zero-wait write
        n_att = 1; att_wait[0] = 0; att_resp[0] = R_ACK;
        run_xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, 32'h0);

        // Read with three wait cycles
        n_att = 1; att_wait[0] = 3; att_resp[0] = R_ACK;
        run_xfer(1'b0, 32'h204, 32'h0, 4'b0000, 32'h12345678);

        // Two retries then ack
        n_att = 3;
        att_wait[0] = 0; att_resp[0] = R_RTY;
        att_wait[1] = 0; att_resp[1] = R_RTY;
        att_wait[2] = 0; att_resp[2] = R_ACK;
        run_xfer(1'b1, 32'h308, 32'hA5A5_0001, 4'b1111, 32'h0);

        // Four retries exhaust the budget on a read
        n_att = 4;
        for (int k = 0; k < 4; k++) begin att_wait[k] = 1; att_resp[k] = R_RTY; end
        run_xfer(1'b0, 32'h40C, 32'h0, 4'b0000, 32'hFFFF_0000);

        // Good read, then err+ack on a read must return zero
        n_att = 1; att_wait[0] = 0; att_resp[0] = R_ACK;
        run_xfer(1'b0, 32'h500, 32'h0, 4'b0000, 32'hCAFE_F00D);
        n_att = 1; att_wait[0] = 2; att_resp[0] = R_ERRACK;
        run_xfer(1'b0, 32'h504, 32'h0, 4'b0000, 32'h1111_2222);

        // Good read, then a write must leave prdata untouched
        n_att = 1; att_wait[0] = 1; att_resp[0] = R_ACK;
        run_xfer(1'b0, 32'h600, 32'h0, 4'b0000, 32'h7777_8888);
        n_att = 1; att_wait[0] = 0; att_resp[0] = R_ERR;
        run_xfer(1'b1, 32'h604, 32'h0BAD_0BAD, 4'b1000, 32'h9999_AAAA);

        // Silent slave
        n_att = 1; att_wait[0] = 1000; att_resp[0] = R_ACK;
        run_xfer(1'b1, 32'h700, 32'h1234_0000, 4'b0101, 32'h0);

        // Reset while stb_o is high
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h800;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            penable = 1'b1;
        end
        check("stb_before_reset", 128'(stb_o), 128'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_apb", 128'({pready, pslverr, prdata}), 128'(0));
        check("midreset_wb", 128'({cyc_o, stb_o, we_o, sel_o, adr_o, dat_o}), 128'(0));
        exp_prdata = 32'h0;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("no_pready_after_reset", 128'({pready, cyc_o}), 128'(0));
        end
        n_att = 1; att_wait[0] = 0; att_resp[0] = R_ACK;
        run_xfer(1'b1, 32'h900, 32'h5555_AAAA, 4'b1100, 32'h0);

        // Randomized back-to-back transfers
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            n_att = 0;
            for (int k = 0; k < 6; k++) begin
                att_wait[k] = $urandom_range(0, 3);
                r = $urandom_range(0, 9);
                if (k == 5 || r < 4)  att_resp[k] = R_ACK;
                else if (r < 5)       att_resp[k] = R_ERR;
                else if (r < 6)       att_resp[k] = R_ERRACK;
                else                  att_resp[k] = R_RTY;
                n_att++;
                if (att_resp[k] != R_RTY) break;
            end
            run_xfer(wr, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
